tff_bank: RTL and testbench



---
 rtl/tff_bank_pkg.sv | 15 +
 rtl/tff_chan.sv | 75 +++++++
 rtl/tff_bank.sv | 60 ++++++
 tb/tb_tff_bank.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tff_bank_pkg.sv
// Shared types and constants for the toggle flip-flop bank.
// Op encoding and event-counter sizing live here.
package tff_bank_pkg;

  typedef enum logic [1:0] {
    OP_TOGGLE = 2'd0,
    OP_SET    = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_LOAD   = 2'd3
  } tff_op_e;

  localparam int EV_CNT_W = 16;
  localparam logic [EV_CNT_W-1:0] EV_CNT_MAX = '1;

endpackage

// File: rtl/tff_chan.sv
// One bank channel: q bit, prescale counter and registered change flag.
// chg is the combinational next-edge change, used by the bank event counter.
module tff_chan
  import tff_bank_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  tff_op_e          op,
  input  logic             t,
  input  logic             d,
  input  logic [DIV_W-1:0] div,
  output logic             q,
  output logic             toggled,
  output logic             chg
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nx;
  logic             q_nx;

  always_comb begin
    q_nx   = q;
    cnt_nx = cnt;
    if (en) begin
      unique case (op)
        OP_TOGGLE: begin
          if (t) begin
            // >= lets a lowered div fire on the very next pulse
            if (cnt >= div) begin
              q_nx   = ~q;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        OP_SET: begin
          if (t) begin
            q_nx   = 1'b1;
            cnt_nx = '0;
          end
        end
        OP_CLEAR: begin
          if (t) begin
            q_nx   = 1'b0;
            cnt_nx = '0;
          end
        end
        OP_LOAD: begin
          q_nx   = d;
          cnt_nx = '0;
        end
        default: ;
      endcase
    end
  end

  assign chg = q_nx ^ q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= 1'b0;
      cnt     <= '0;
      toggled <= 1'b0;
    end else begin
      q       <= q_nx;
      cnt     <= cnt_nx;
      toggled <= chg;
    end
  end

endmodule

// File: rtl/tff_bank.sv
// Bank of WIDTH prescaled toggle flip-flops with set/clear/load ops.
// Optional saturating change-event counter under TFF_BANK_EVCNT_EN.
module tff_bank
  import tff_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] toggled
`ifdef TFF_BANK_EVCNT_EN
  ,
  output logic [EV_CNT_W-1:0] ev_cnt
`endif
);

  tff_op_e          op_e;
  logic [WIDTH-1:0] chg;

  assign op_e = tff_op_e'(op);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    tff_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .op     (op_e),
      .t      (t[i]),
      .d      (d[i]),
      .div    (div),
      .q      (q[i]),
      .toggled(toggled[i]),
      .chg    (chg[i])
    );
  end

`ifdef TFF_BANK_EVCNT_EN
  // chg is already zero when en is low; en kept for clarity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_cnt <= '0;
    end else if (en && (|chg) && ev_cnt != EV_CNT_MAX) begin
      ev_cnt <= ev_cnt + 1'b1;
    end
  end
`else
  logic unused_chg;
  assign unused_chg = ^chg;
`endif

endmodule

// File: tb/tb_tff_bank.sv
// Table-driven bench for tff_bank with an expected-value queue.
// Event counter checks compile in with TFF_BANK_EVCNT_EN.
`timescale 1ns/100ps
module tb_tff_bank;
  import tff_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] op = 2'd0;
  logic [7:0] t = '0;
  logic [7:0] d = '0;
  logic [3:0] div = '0;
  logic [7:0] q;
  logic [7:0] toggled;
`ifdef TFF_BANK_EVCNT_EN
  logic [15:0] ev_cnt;
`endif

  int total = 0;
  int bad = 0;
  int exp_ev = 0;

  typedef struct {
    logic       en;
    logic [1:0] op;
    logic [7:0] t;
    logic [7:0] d;
    logic [3:0] dv;
    logic [7:0] q;
    logic [7:0] tg;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] tg;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  tff_bank #(.WIDTH(8), .DIV_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .op     (op),
    .t      (t),
    .d      (d),
    .div    (div),
    .q      (q),
    .toggled(toggled)
`ifdef TFF_BANK_EVCNT_EN
    ,
    .ev_cnt (ev_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic e, logic [1:0] o, logic [7:0] tt,
                              logic [7:0] dd, logic [3:0] dv,
                              logic [7:0] eq, logic [7:0] etg);
    vec_t v;
    v.en = e; v.op = o; v.t = tt; v.d = dd; v.dv = dv;
    v.q = eq; v.tg = etg;
    return v;
  endfunction

  task automatic cmp8(string nm, logic [7:0] act, logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic check_ev(string nm);
`ifdef TFF_BANK_EVCNT_EN
    total++;
    if (ev_cnt !== 16'(exp_ev)) begin
      bad++;
      $display("FAIL %s: ev_cnt got %h want %h", nm, ev_cnt, 16'(exp_ev));
    end
`else
    if (nm.len() == 0) exp_ev = 0;
`endif
  endtask

  task automatic apply(vec_t v, string nm);
    exp_t e;
    @(negedge clk);
    en = v.en; op = v.op; t = v.t; d = v.d; div = v.dv;
    e.q = v.q; e.tg = v.tg;
    sb.push_back(e);
    if (v.tg != 0 && exp_ev < 16'hFFFF) exp_ev++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp8({nm, ".q"}, q, e.q);
    cmp8({nm, ".toggled"}, toggled, e.tg);
    check_ev(nm);
  endtask

  task automatic rst_pulse(string nm);
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #0.5;
    exp_ev = 0;
    cmp8({nm, ".q"}, q, 8'h00);
    cmp8({nm, ".toggled"}, toggled, 8'h00);
    check_ev(nm);
    #0.5 rst = 1'b0;
  endtask

  initial begin
    // plain toggle, div=0
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1, 0, 8'h0F, 0, 0, (i % 2 == 0) ? 8'h0F : 8'h00, 8'h0F));
    // prescale div=2 on channel 0: flips on pulses 3, 6, 9
    for (int i = 1; i <= 9; i++)
      vt.push_back(mk(1, 0, 8'h01, 0, 2,
                      (i >= 3 && i < 6) || i >= 9 ? 8'h01 : 8'h00,
                      (i % 3 == 0) ? 8'h01 : 8'h00));
    vt.push_back(mk(1, 0, 8'h01, 0, 2, 8'h01, 8'h00));
    vt.push_back(mk(1, 0, 8'h01, 0, 2, 8'h01, 8'h00));
    // cnt=2, div lowered to 0: flips at once
    vt.push_back(mk(1, 0, 8'h01, 0, 0, 8'h00, 8'h01));
    // set / clear / load
    vt.push_back(mk(1, 3, 8'h00, 8'hA5, 0, 8'hA5, 8'hA5));
    vt.push_back(mk(1, 1, 8'h0F, 8'h00, 0, 8'hAF, 8'h0A));
    vt.push_back(mk(1, 2, 8'hF0, 8'h00, 0, 8'h0F, 8'hA0));
    vt.push_back(mk(1, 3, 8'h00, 8'h3C, 0, 8'h3C, 8'h33));
    // hold
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(0, 0, 8'hFF, 8'h00, 0, 8'h3C, 8'h00));
    // one pulse leaves cnt[0]=1
    vt.push_back(mk(1, 0, 8'h01, 8'h00, 2, 8'h3C, 8'h00));

    #1;
    cmp8("reset.q", q, 8'h00);
    cmp8("reset.toggled", toggled, 8'h00);
    check_ev("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));

    // async reset mid-count, then 3 fresh pulses needed
    rst_pulse("rst_mid");
    apply(mk(1, 0, 8'h01, 0, 2, 8'h00, 8'h00), "post_rst1");
    apply(mk(1, 0, 8'h01, 0, 2, 8'h00, 8'h00), "post_rst2");
    apply(mk(1, 0, 8'h01, 0, 2, 8'h01, 8'h01), "post_rst3");

    // SET/CLEAR on unchanged bits must not flag
    apply(mk(1, 1, 8'h01, 0, 0, 8'h01, 8'h00), "set_same");
    apply(mk(1, 2, 8'hF0, 0, 0, 8'h01, 8'h00), "clr_same");

`ifdef TFF_BANK_EVCNT_EN
    rst_pulse("ev_rst");
    for (int i = 0; i < 5; i++)
      apply(mk(1, 0, 8'h80, 0, 0, (i % 2 == 0) ? 8'h80 : 8'h00, 8'h80),
            $sformatf("ev_chg%0d", i));
    apply(mk(1, 0, 8'h00, 0, 0, 8'h80, 8'h00), "ev_idle0");
    apply(mk(0, 0, 8'hFF, 0, 0, 8'h80, 8'h00), "ev_idle1");
    total++;
    if (exp_ev != 5 || ev_cnt !== 16'd5) begin
      bad++;
      $display("FAIL ev_five: got %0d want 5", ev_cnt);
    end
    @(negedge clk);
    en = 1'b1; op = 2'd0; t = 8'h01; div = 4'd0;
    repeat (65535) @(posedge clk);
    #1;
    total++;
    if (ev_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL ev_sat: got %h want ffff", ev_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ev_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL ev_hold_sat: got %h want ffff", ev_cnt);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
